// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues single-word requests to the inst_cache and buffers
// responses in a 2-entry queue for decode. Optional fetch timeout under INST_FETCH_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | no request outstanding, waiting for a free queue slot
// S_REQ  | inst_get pulse, ptr presented to the cache
// S_WAIT | request outstanding, waiting for ready (squash drops a stale response)
module inst_fetch #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   PC_STEP   = 1,
  parameter int                   TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] ptr,
  output logic                 inst_get,
  input  logic                 ready,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 dec_stall,
  output logic                 dec_valid,
  output logic [WORD_SIZE-1:0] dec_inst,
  output logic [WORD_SIZE-1:0] dec_pc,
  output logic                 fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc, pc_nxt;
  logic                 squash, squash_nxt;
  logic [1:0]           count, count_nxt;
  logic                 push, pop, timeout;
  logic [WORD_SIZE-1:0] q0_inst, q0_pc, q1_inst, q1_pc;

  assign dec_valid = (count != 2'd0);
  assign dec_inst  = q0_inst;
  assign dec_pc    = q0_pc;

`ifdef INST_FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  assign timeout   = (state == S_WAIT) && !ready && (tmo_cnt == 4'd0);
  assign fetch_err = err_q;

  // Down-counter reloads outside WAIT and on every response; terminal count means timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= 4'(TIMEOUT - 1);
      err_q   <= 1'b0;
    end else begin
      if (state != S_WAIT || ready)
        tmo_cnt <= 4'(TIMEOUT - 1);
      else if (tmo_cnt != 4'd0)
        tmo_cnt <= tmo_cnt - 4'd1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    pop  = dec_valid && !dec_stall;
    push = (state == S_WAIT) && ready && !squash && !redirect;

    count_nxt = count;
    if (redirect)
      count_nxt = 2'd0;
    else if (push && !pop)
      count_nxt = count + 2'd1;
    else if (!push && pop)
      count_nxt = count - 2'd1;

    state_nxt  = state;
    pc_nxt     = pc;
    squash_nxt = squash;

    if (redirect) begin
      pc_nxt = redirect_pc;
      // An outstanding request must still be answered before a new one can be issued.
      if (state == S_REQ || (state == S_WAIT && !ready)) begin
        state_nxt  = S_WAIT;
        squash_nxt = 1'b1;
      end else begin
        state_nxt  = S_REQ;
        squash_nxt = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: if (count_nxt != 2'd2) state_nxt = S_REQ;
        S_REQ:  state_nxt = S_WAIT;
        S_WAIT: begin
          if (ready) begin
            squash_nxt = 1'b0;
            if (squash) begin
              state_nxt = S_REQ;
            end else begin
              pc_nxt    = pc + WORD_SIZE'(PC_STEP);
              state_nxt = (count_nxt != 2'd2) ? S_REQ : S_IDLE;
            end
          end else if (timeout) begin
            state_nxt  = S_REQ;
            squash_nxt = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ptr      <= RESET_PC;
      inst_get <= 1'b0;
      squash   <= 1'b0;
      count    <= 2'd0;
      q0_inst  <= '0;
      q0_pc    <= '0;
      q1_inst  <= '0;
      q1_pc    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      squash   <= squash_nxt;
      count    <= count_nxt;
      inst_get <= (state_nxt == S_REQ);
      if (state_nxt == S_REQ)
        ptr <= pc_nxt;

      // Shift-style queue: entry 0 is always the head seen by decode.
      if (!redirect) begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              q0_inst <= inst;
              q0_pc   <= pc;
            end else begin
              q1_inst <= inst;
              q1_pc   <= pc;
            end
          end
          2'b01: begin
            q0_inst <= q1_inst;
            q0_pc   <= q1_pc;
          end
          2'b11: begin
            if (count == 2'd1) begin
              q0_inst <= inst;
              q0_pc   <= pc;
            end else begin
              q0_inst <= q1_inst;
              q0_pc   <= q1_pc;
              q1_inst <= inst;
              q1_pc   <= pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
